// File: rtl/seq_pattern_detector.sv
// ============================================================================
// seq_pattern_detector
//
// Serial bit-pattern detector. It compares a runtime-loadable PAT_LEN-bit
// pattern against the most recent PAT_LEN qualified bits of a serial stream.
// Matching can be overlapping or non-overlapping, and the mode is chosen per
// sampled bit.
//
// Parameters
//   PAT_LEN  pattern length in bits (2..16)
//   RST_PAT  pattern register value after reset
//   CNT_W    width of the optional saturating match counter
//
// Ports
//   clock        rising-edge system clock
//   resetn       asynchronous active-low reset
//   w            serial data bit
//   bit_valid    w is sampled on this edge only when high
//   overlap      1 = overlapping matches, 0 = non-overlapping
//   pat_in       new pattern; bit PAT_LEN-1 is compared with the oldest bit
//   pat_load     load pat_in into the pattern register (drops any bit this cycle)
//   match        registered one-cycle pulse on a detected match
//   state        0 = IDLE, 1 = HUNT, 2 = ARMED (coarse view of fill, for LEDs)
//   fill         number of valid history bits, saturating at PAT_LEN
//   match_count  saturating match counter, or constant 0 when compiled out
//
// Optional feature
//   Define SEQDET_MATCH_CNT_EN to build the match counter. Without it,
//   match_count is tied to 0 and no counter flops exist.
// ============================================================================
module seq_pattern_detector #(
    parameter int                 PAT_LEN = 4,
    parameter logic [PAT_LEN-1:0] RST_PAT = 4'b1101,
    parameter int                 CNT_W   = 8
) (
    input  logic                         clock,
    input  logic                         resetn,
    input  logic                         w,
    input  logic                         bit_valid,
    input  logic                         overlap,
    input  logic [PAT_LEN-1:0]           pat_in,
    input  logic                         pat_load,
    output logic                         match,
    output logic [1:0]                   state,
    output logic [$clog2(PAT_LEN+1)-1:0] fill,
    output logic [CNT_W-1:0]             match_count
);

    localparam int                FILL_W    = $clog2(PAT_LEN + 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_LEN);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_HUNT  = 2'd1;
    localparam logic [1:0] ST_ARMED = 2'd2;

    logic [PAT_LEN-1:0] pattern_q;
    // Only the newest PAT_LEN-1 bits are kept. The oldest bit of a PAT_LEN-bit
    // history would be shifted out on the same edge it could first be compared,
    // so it is never observable.
    logic [PAT_LEN-2:0] hist_q;
    logic [FILL_W-1:0]  fill_q;
    logic [1:0]         state_q;
    logic               match_q;

    logic [PAT_LEN-1:0] window;
    logic [FILL_W-1:0]  fill_inc;
    logic [FILL_W-1:0]  fill_next;
    logic [1:0]         state_next;
    logic               hit;
    logic               match_next;

    function automatic logic [1:0] state_of(input logic [FILL_W-1:0] f);
        if (f == '0)
            return ST_IDLE;
        else if (f == FILL_FULL)
            return ST_ARMED;
        else
            return ST_HUNT;
    endfunction

    // Next-state logic. window is the history as it will look after this bit.
    always_comb begin
        window     = {hist_q, w};
        fill_inc   = (fill_q == FILL_FULL) ? FILL_FULL : fill_q + FILL_W'(1);
        hit        = (fill_inc == FILL_FULL) && (window == pattern_q);
        fill_next  = fill_q;
        match_next = 1'b0;
        if (pat_load) begin
            fill_next = '0;
        end else if (bit_valid) begin
            match_next = hit;
            // Non-overlapping mode discards the matched bits by emptying fill;
            // the history bits stay but are ignored until refilled.
            fill_next  = (hit && !overlap) ? '0 : fill_inc;
        end
        state_next = state_of(fill_next);
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            pattern_q <= RST_PAT;
            hist_q    <= '0;
            fill_q    <= '0;
            state_q   <= ST_IDLE;
            match_q   <= 1'b0;
        end else begin
            if (pat_load)
                pattern_q <= pat_in;
            else if (bit_valid)
                hist_q <= window[PAT_LEN-2:0];
            fill_q  <= fill_next;
            state_q <= state_next;
            match_q <= match_next;
        end
    end

`ifdef SEQDET_MATCH_CNT_EN
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn)
            cnt_q <= '0;
        else if (pat_load)
            cnt_q <= '0;
        else if (match_next && (cnt_q != {CNT_W{1'b1}}))
            cnt_q <= cnt_q + CNT_W'(1);
    end

    assign match_count = cnt_q;
`else
    assign match_count = '0;
`endif

    assign match = match_q;
    assign state = state_q;
    assign fill  = fill_q;

endmodule
